// File: rtl/ctech_lib_latch_rf_wr_ctrl.sv
// ---------------------------------------------------------------------------
// ctech_lib_latch_rf_wr_ctrl
//
// Write-port sequencer for a latch-based register file. One write is taken
// per valid/ready handshake. The data is staged on a shared bus, then exactly
// one row enable is pulsed high for OPEN_CYC cycles. Data is held stable for
// a full cycle before the enable rises and a full cycle after it falls.
//
// latch_en[i] drives the clk pin of row i; latch_d drives the d pins of all
// rows. Both come straight from flops, so the latch clocks are glitch-free.
//
// Ports
//   clk       : single clock
//   rst       : synchronous, active-high reset
//   wr_vld    : write request valid
//   wr_rdy    : controller can accept a write (idle and not in reset)
//   wr_addr   : target row, sampled only on accept
//   wr_data   : write data, sampled only on accept
//   latch_en  : one-hot row enables (at most one bit high)
//   latch_d   : staged write data
//   wr_done   : one-cycle pulse when a write has completed
//   wr_err    : one-cycle pulse when an out-of-range write was dropped
//
// State table
//   state   | meaning
//   --------+-------------------------------------------------
//   S_IDLE  | waiting for a write; latch_d held, enables low
//   S_SETUP | data driven on latch_d, enables still low
//   S_OPEN  | selected enable high for OPEN_CYC cycles
//   S_HOLD  | enables low, data held, wr_done high
// ---------------------------------------------------------------------------
module ctech_lib_latch_rf_wr_ctrl #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 32,
    parameter int OPEN_CYC = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [DEPTH-1:0] latch_en,
    output logic [WIDTH-1:0] latch_d,
    output logic             wr_done,
    output logic             wr_err
);

    // OPEN_CYC is at most 15, so a 4-bit down-counter covers every legal value.
    localparam int          CW        = 4;
    localparam logic [CW-1:0] OPEN_LOAD = CW'(OPEN_CYC - 1);

    // One extra bit so DEPTH itself is representable when DEPTH is a power of 2.
    localparam logic [AW:0] DEPTH_W   = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_OPEN  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [AW-1:0]     addr_q;
    logic [AW-1:0]     addr_nxt;
    logic [CW-1:0]     open_cnt;
    logic [CW-1:0]     cnt_nxt;
    logic [DEPTH-1:0]  en_nxt;
    logic [WIDTH-1:0]  d_nxt;
    logic              done_nxt;
    logic              err_nxt;

    logic              accept;
    logic              in_range;
    logic              cnt_tc;
    logic [DEPTH-1:0]  row_sel;

    assign wr_rdy   = (state == S_IDLE) && !rst;
    assign accept   = wr_vld && wr_rdy;
    assign in_range = ({1'b0, wr_addr} < DEPTH_W);
    assign cnt_tc   = (open_cnt == '0);

    // Decode of the registered address; addr_q is always < DEPTH here.
    always_comb begin
        row_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            row_sel[i] = (addr_q == AW'(i));
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            open_cnt <= '0;
            latch_en <= '0;
            latch_d  <= '0;
            wr_done  <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            addr_q   <= addr_nxt;
            open_cnt <= cnt_nxt;
            latch_en <= en_nxt;
            latch_d  <= d_nxt;
            wr_done  <= done_nxt;
            wr_err   <= err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                // Out-of-range writes are dropped without leaving IDLE so the
                // requester can issue the next write on the following cycle.
                if (accept && in_range) begin
                    state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                state_nxt = S_OPEN;
            end
            S_OPEN: begin
                if (cnt_tc) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values (all registered above)
    // ------------------------------------------------------------------
    always_comb begin
        addr_nxt = addr_q;
        cnt_nxt  = open_cnt;
        d_nxt    = latch_d;
        en_nxt   = '0;
        done_nxt = 1'b0;
        err_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (in_range) begin
                        addr_nxt = wr_addr;
                        d_nxt    = wr_data;
                    end else begin
                        err_nxt  = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                en_nxt  = row_sel;
                cnt_nxt = OPEN_LOAD;
            end
            S_OPEN: begin
                // Enable stays up until the counter reaches terminal count;
                // dropping it and raising wr_done land on the same edge.
                if (!cnt_tc) begin
                    cnt_nxt = open_cnt - CW'(1);
                    en_nxt  = latch_en;
                end else begin
                    done_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                en_nxt = '0;
            end
            default: begin
                en_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_ctech_lib_latch_rf_wr_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for ctech_lib_latch_rf_wr_ctrl. Three instances cover the default
// configuration, a long enable pulse (OPEN_CYC=4) and a non-power-of-2 depth
// (DEPTH=6). A timeline model (cycles since accept) predicts every output on
// every cycle; directed sequences add literal expectations.
// ---------------------------------------------------------------------------
module tb_ctech_lib_latch_rf_wr_ctrl;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // per-instance parameters
    int depth_p [N] = '{8, 8, 6};
    int oc_p    [N] = '{1, 4, 1};

    logic        rst_i  [N];
    logic        vld_i  [N];
    logic [2:0]  addr_i [N];
    logic [31:0] data_i [N];

    logic        rdy_o  [N];
    logic        done_o [N];
    logic        err_o  [N];
    logic [31:0] d_o    [N];
    logic [7:0]  en0, en1;
    logic [5:0]  en2;
    logic [7:0]  en_o   [N];

    assign en_o[0] = en0;
    assign en_o[1] = en1;
    assign en_o[2] = {2'b00, en2};

    ctech_lib_latch_rf_wr_ctrl #(.DEPTH(8), .WIDTH(32), .OPEN_CYC(1)) u_dut0 (
        .clk(clk), .rst(rst_i[0]), .wr_vld(vld_i[0]), .wr_rdy(rdy_o[0]),
        .wr_addr(addr_i[0]), .wr_data(data_i[0]), .latch_en(en0),
        .latch_d(d_o[0]), .wr_done(done_o[0]), .wr_err(err_o[0]));

    ctech_lib_latch_rf_wr_ctrl #(.DEPTH(8), .WIDTH(32), .OPEN_CYC(4)) u_dut1 (
        .clk(clk), .rst(rst_i[1]), .wr_vld(vld_i[1]), .wr_rdy(rdy_o[1]),
        .wr_addr(addr_i[1]), .wr_data(data_i[1]), .latch_en(en1),
        .latch_d(d_o[1]), .wr_done(done_o[1]), .wr_err(err_o[1]));

    ctech_lib_latch_rf_wr_ctrl #(.DEPTH(6), .WIDTH(32), .OPEN_CYC(1)) u_dut2 (
        .clk(clk), .rst(rst_i[2]), .wr_vld(vld_i[2]), .wr_rdy(rdy_o[2]),
        .wr_addr(addr_i[2]), .wr_data(data_i[2]), .latch_en(en2),
        .latch_d(d_o[2]), .wr_done(done_o[2]), .wr_err(err_o[2]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Timeline model: a write accepted at edge T is busy for phases
    // 1..OPEN_CYC+2 after T; enable during 2..OPEN_CYC+1, done at OPEN_CYC+2.
    // ------------------------------------------------------------------
    bit          m_valid [N];
    bit          m_busy  [N];
    bit          m_err   [N];
    int          m_ph    [N];
    int          m_addr  [N];
    logic [31:0] m_d     [N];
    logic [31:0] prev_d  [N];
    logic [7:0]  prev_en [N];
    bit          prev_rst[N];
    int          done_cnt[N];
    int          acc_cnt [N];
    logic [7:0]  exp_en;

    initial begin
        for (int k = 0; k < N; k++) begin
            m_valid[k] = 0; m_busy[k] = 0; m_err[k] = 0; m_ph[k] = 0; m_addr[k] = 0;
            m_d[k] = '0; prev_d[k] = '0; prev_en[k] = '0; prev_rst[k] = 1;
            done_cnt[k] = 0; acc_cnt[k] = 0;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (m_valid[k]) begin
                exp_en = (m_busy[k] && m_ph[k] >= 2 && m_ph[k] <= 1 + oc_p[k])
                         ? 8'(1 << m_addr[k]) : 8'h00;
                chk($sformatf("latch_en[%0d]", k), en_o[k], exp_en);
                chk($sformatf("wr_rdy[%0d]", k), rdy_o[k], !rst_i[k] && !m_busy[k]);
                chk($sformatf("wr_done[%0d]", k), done_o[k], m_busy[k] && m_ph[k] == 2 + oc_p[k]);
                chk($sformatf("wr_err[%0d]", k), err_o[k], m_err[k]);
                chk($sformatf("latch_d[%0d]", k), d_o[k], m_d[k]);
                chk($sformatf("onehot[%0d]", k), $onehot0(en_o[k]), 1'b1);
                if (!prev_rst[k] && (en_o[k] != 0 || prev_en[k] != 0))
                    chk($sformatf("d_margin[%0d]", k), d_o[k], prev_d[k]);
                if (done_o[k] === 1'b1) done_cnt[k]++;
            end
            prev_en[k]  = en_o[k];
            prev_d[k]   = d_o[k];
            prev_rst[k] = rst_i[k];
            // advance the model across the coming edge
            if (rst_i[k]) begin
                m_valid[k] = 1; m_busy[k] = 0; m_err[k] = 0; m_ph[k] = 0; m_d[k] = '0;
            end else if (m_valid[k]) begin
                m_err[k] = 0;
                if (m_busy[k]) begin
                    m_ph[k]++;
                    if (m_ph[k] > 2 + oc_p[k]) m_busy[k] = 0;
                end else if (vld_i[k]) begin
                    if (int'(addr_i[k]) < depth_p[k]) begin
                        m_busy[k] = 1; m_ph[k] = 1; m_addr[k] = int'(addr_i[k]);
                        m_d[k] = data_i[k]; acc_cnt[k]++;
                    end else begin
                        m_err[k] = 1;
                    end
                end
            end
        end
    end

    // Drive a request shortly after a posedge; returns right at the accept edge.
    task automatic wr(input int k, input logic [2:0] a, input logic [31:0] dt, output int t_acc);
        logic r;
        #1;
        vld_i[k] = 1'b1; addr_i[k] = a; data_i[k] = dt;
        t_acc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            r = rdy_o[k];
            if (r === 1'b1) t_acc = cyc;
            @(posedge clk);
            if (r === 1'b1) break;
        end
        if (t_acc < 0) begin
            checks++; failures++;
            $display("FAIL accept_timeout inst=%0d got=no_accept expected=accept", k);
        end
    endtask

    int t0, t1, t2;

    initial begin
        for (int k = 0; k < N; k++) begin
            rst_i[k] = 1'b1; vld_i[k] = 1'b0; addr_i[k] = '0; data_i[k] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_en", en0, 8'h00);
        chk("rst_d", d_o[0], 32'h0);
        chk("rst_done", done_o[0], 1'b0);
        chk("rst_err", err_o[0], 1'b0);
        chk("rst_rdy", rdy_o[0], 1'b0);
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) rst_i[k] = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst", rdy_o[0], 1'b1);
        @(posedge clk);

        // basic write on default instance
        wr(0, 3'd3, 32'hDEADBEEF, t0);
        #1 vld_i[0] = 1'b0;
        @(negedge clk); chk("basic_d_T1", d_o[0], 32'hDEADBEEF); chk("basic_en_T1", en0, 8'h00);
        @(negedge clk); chk("basic_en_T2", en0, 8'h08);
        @(negedge clk); chk("basic_en_T3", en0, 8'h00); chk("basic_done_T3", done_o[0], 1'b1);
        @(negedge clk); chk("basic_rdy_T4", rdy_o[0], 1'b1); chk("basic_done_T4", done_o[0], 1'b0);
        @(posedge clk);

        // back-to-back with wr_vld held high
        wr(0, 3'd0, 32'h0000_1110, t0);
        wr(0, 3'd1, 32'h0000_2221, t1);
        wr(0, 3'd2, 32'h0000_3332, t2);
        #1 vld_i[0] = 1'b0;
        chk("b2b_gap1", t1 - t0, 4);
        chk("b2b_gap2", t2 - t1, 4);
        repeat (6) @(posedge clk);
        chk("dut0_done_cnt", done_cnt[0], 4);

        // long pulse
        wr(1, 3'd7, 32'h7777_0007, t0);
        #1 vld_i[1] = 1'b0;
        @(negedge clk); chk("long_en_T1", en1, 8'h00);
        for (int i = 2; i <= 5; i++) begin
            @(negedge clk); chk($sformatf("long_en_T%0d", i), en1, 8'h80);
        end
        @(negedge clk); chk("long_en_T6", en1, 8'h00); chk("long_done_T6", done_o[1], 1'b1);
        @(posedge clk);

        // reset while OPEN
        wr(1, 3'd2, 32'hCAFE_0002, t0);
        #1 vld_i[1] = 1'b0;
        @(posedge clk);
        #1 rst_i[1] = 1'b1;
        @(negedge clk); chk("mid_en_open", en1, 8'h04);
        @(posedge clk);
        #1 rst_i[1] = 1'b0;
        @(negedge clk);
        chk("mid_en", en1, 8'h00); chk("mid_d", d_o[1], 32'h0);
        chk("mid_done", done_o[1], 1'b0); chk("mid_rdy", rdy_o[1], 1'b1);
        repeat (6) @(posedge clk);
        chk("mid_no_done", done_cnt[1], 1);

        // out-of-range on DEPTH=6
        wr(2, 3'd1, 32'hAAAA_5555, t0);
        #1 vld_i[2] = 1'b0;
        repeat (5) @(posedge clk);
        wr(2, 3'd6, 32'h0000_1234, t0);
        #1 addr_i[2] = 3'd5; data_i[2] = 32'h5A5A_5A5A;
        @(negedge clk);
        chk("oor_err", err_o[2], 1'b1); chk("oor_en", en2, 6'h00);
        chk("oor_d", d_o[2], 32'hAAAA_5555); chk("oor_rdy", rdy_o[2], 1'b1);
        @(posedge clk);
        #1 vld_i[2] = 1'b0;
        @(negedge clk); chk("oor_next_d", d_o[2], 32'h5A5A_5A5A); chk("oor_next_err", err_o[2], 1'b0);
        @(negedge clk); chk("oor_next_en", en2, 6'h20);
        @(negedge clk); chk("oor_next_done", done_o[2], 1'b1);
        @(posedge clk);

        // random stress
        for (int n = 0; n < 10000; n++) begin
            wr(2, 3'($urandom_range(0, 7)), $urandom, t0);
            if ($urandom_range(0, 3) == 0) begin
                #1 vld_i[2] = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
            end
        end
        #1 vld_i[2] = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("stress_done_cnt", done_cnt[2], acc_cnt[2]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ctech_lib_latch_rf_wr_ctrl.md
# ctech_lib_latch_rf_wr_ctrl

Write-port sequencer for latch-based register files built from `ctech_lib_latch` cells. It accepts one write per valid/ready handshake and stages the write data on a shared data bus. It then pulses exactly one registered, glitch-free, one-hot latch enable with guaranteed setup and hold margins around the pulse. It sits directly upstream of the latch array: `latch_en[i]` drives the `clk` pin and `latch_d` drives the `d` pins of row `i`.

## Interface
- `DEPTH`, default 8: number of latch rows; legal range 2..64.
- `WIDTH`, default 32: data width per row.
- `OPEN_CYC`, default 1: number of cycles the enable is held high; legal range 1..15.
- `AW`, default `$clog2(DEPTH)`: address width. Derived; do not override.
- `clk`, input, 1: the single clock.
- `rst`, input, 1: synchronous, active-high reset.
- `wr_vld`, input, 1: write request valid.
- `wr_rdy`, output, 1: controller can accept a write.
- `wr_addr`, input, AW: target row.
- `wr_data`, input, WIDTH: write data.
- `latch_en`, output, DEPTH: one-hot latch enables. Every bit is driven directly from a flop.
- `latch_d`, output, WIDTH: staged data. Driven directly from flops.
- `wr_done`, output, 1: one-cycle pulse marking completion of a write.
- `wr_err`, output, 1: one-cycle pulse marking a dropped out-of-range write.

## Operation
- States:
  - IDLE: waiting for a write.
  - SETUP: data driven, enables low.
  - OPEN: selected enable high.
  - HOLD: enables low, data held.
- Handshake: `wr_rdy = (state == IDLE) && !rst`, combinational from state. A write is accepted on any cycle with `wr_vld && wr_rdy`.
- On accept with `wr_addr < DEPTH`:
  - Register the address.
  - Load `latch_d <= wr_data`.
  - Go to SETUP.
- On accept with `wr_addr >= DEPTH` (possible only when DEPTH is not a power of 2):
  - Pulse `wr_err` for one cycle.
  - Leave `latch_d` unchanged and raise no enable.
  - Stay in IDLE.
- SETUP -> OPEN: set `latch_en[addr] <= 1` and load an open counter with `OPEN_CYC - 1`.
- OPEN:
  - If the counter is nonzero, decrement it and stay in OPEN.
  - If the counter is zero, clear all enables and go to HOLD.
- HOLD:
  - Assert `wr_done`.
  - `latch_d` is held unchanged.
  - Next state is IDLE.
- `latch_d` changes only on an accepted in-range write or on reset. It holds its value in IDLE so the latches see a stable `d`.
- At most one `latch_en` bit is ever high. `latch_en` is zero in every state except OPEN.
- `wr_addr` and `wr_data` are sampled only at accept. Changes to them while `wr_rdy` is low are ignored.

## Timing
- Reset values (on the edge where `rst` = 1):
  - state = IDLE
  - `latch_en` = 0
  - `latch_d` = 0
  - `wr_done` = 0
  - `wr_err` = 0
  - open counter = 0
  - `wr_rdy` = 0 while `rst` is high
- Accept at edge T. Then:
  - T+1: SETUP, `latch_d` valid, enables still 0.
  - T+2 .. T+1+OPEN_CYC: `latch_en[addr]` = 1.
  - T+2+OPEN_CYC: HOLD, enables 0, `wr_done` = 1.
  - T+3+OPEN_CYC: IDLE, `wr_rdy` = 1.
- Throughput: one write every OPEN_CYC+3 cycles. Back-to-back requests are accepted on the first IDLE cycle.
- Margins: data is stable at least 1 full cycle before the enable rises and at least 1 full cycle after it falls.
- Out-of-range accept at T:
  - `wr_err` = 1 during T+1 only.
  - `wr_rdy` stays 1, so the next write can be accepted at T+1.
- Reset asserted in any state:
  - All outputs take their reset values at the next edge.
  - Any interrupted write leaves the targeted row undefined.
  - No `wr_done` is produced for the interrupted write.
- `wr_done` and `wr_err` never assert in the same cycle.

## Test plan
- Basic write, default parameters: after reset, write `addr=3`, `data=0xDEADBEEF`.
  - Required: `latch_d` = 0xDEADBEEF from T+1.
  - Required: `latch_en` = 0x08 only at T+2.
  - Required: `wr_done` at T+3, `wr_rdy` at T+4.
- Long pulse, `OPEN_CYC=4`: write `addr=7`.
  - Required: `latch_en` = 0x80 for exactly 4 cycles (T+2..T+5).
  - Required: `wr_done` at T+6.
- Back-to-back: hold `wr_vld` high with writes to addr 0, 1, 2.
  - Required: accepts every 4 cycles (default `OPEN_CYC`).
  - Required: each `latch_en` is one-hot with no overlap.
  - Required: `latch_d` does not change while any enable is high.
- Out-of-range, `DEPTH=6`: write `addr=6` with `data=0x1234`.
  - Required: `wr_err` pulses at T+1.
  - Required: `latch_en` stays 0 and `latch_d` keeps its previous value.
  - Required: a following write to addr 5 completes normally.
- Reset mid-write: assert `rst` while in OPEN with addr 2.
  - Required: next edge gives `latch_en` = 0, `latch_d` = 0, no `wr_done`.
  - Required: `wr_rdy` = 1 on the first cycle after `rst` drops.
- Random stress: 10k random accepts with random addresses and data against a scoreboard row model.
  - Required: every enable is one-hot.
  - Required: setup and hold of ≥1 cycle around every enable pulse.
  - Required: `wr_done` count equals the number of in-range accepts.
